// File: rtl/microseq_pkg.sv
// Shared command encoding for the microsequencer.
package microseq_types;

    localparam int CMD_W = 4;

    typedef enum logic [CMD_W-1:0] {
        NOP    = 4'd0,
        INC    = 4'd1,
        JMP    = 4'd2,
        JCC    = 4'd3,
        CALL   = 4'd4,
        CALLCC = 4'd5,
        RET    = 4'd6,
        RETCC  = 4'd7,
        LDCNT  = 4'd8,
        DJNZ   = 4'd9
    } cmd_t;

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO. A push while full or a pop while empty is dropped and
// reported on o_ovf / o_unf for the same cycle. Entries are not cleared by reset.
module microseq_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [ADDR_W-1:0]              i_data,
    output logic [ADDR_W-1:0]              o_top,
    output logic [$clog2(STACK_DEPTH):0]   o_count,
    output logic                           o_full,
    output logic                           o_empty,
    output logic                           o_ovf,
    output logic                           o_unf
);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic [SP_W-1:0]   r_count;
    logic [PTR_W-1:0]  w_top_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == SP_W'(STACK_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_ovf     = i_push & o_full;
    assign o_unf     = i_pop & o_empty;
    assign w_top_idx = PTR_W'(r_count - 1'b1);
    assign o_top     = r_mem[w_top_idx];
    assign o_count   = r_count;

    // Occupancy count; push and pop never arrive together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + 1'b1;
        end else if (w_do_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Entry storage, written at the current occupancy index.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_count[PTR_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/microseq.sv
// Microsequencer top: next-address selection, condition mux, return stack and
// optional loop counter (built only when MICROSEQ_LOOP_EN is defined).
module microseq
    import microseq_types::*;
#(
    parameter int              ADDR_W      = 8,
    parameter int              STACK_DEPTH = 4,
    parameter int              NFLAGS      = 4,
    parameter int              CNT_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          stall,
    input  logic [CMD_W-1:0]                              cmd,
    input  logic [((NFLAGS > 1) ? $clog2(NFLAGS) : 1)-1:0] cond_sel,
    input  logic                                          cond_inv,
    input  logic [NFLAGS-1:0]                             flags,
    input  logic [ADDR_W-1:0]                             load_addr,
    output logic [ADDR_W-1:0]                             addr,
    output logic [$clog2(STACK_DEPTH):0]                  sp,
    output logic                                          stack_err
);
    localparam int SEL_W = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;

    cmd_t              w_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_next;
    logic [ADDR_W-1:0] w_top;
    logic              r_err;
    logic              w_flag;
    logic              w_cond;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf;
    logic              w_unf;

`ifdef MICROSEQ_LOOP_EN
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_dec;
    assign w_cnt_dec = r_cnt - 1'b1;
`else
    logic [CNT_W-1:0]  w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

    assign w_cmd  = cmd_t'(cmd);
    assign w_next = r_addr + 1'b1;
    assign w_cond = w_flag ^ cond_inv;

    // Flag select; selectors beyond NFLAGS read as 0.
    always_comb begin
        w_flag = 1'b0;
        for (int i = 0; i < NFLAGS; i++) begin
            if (cond_sel == SEL_W'(i)) w_flag = flags[i];
        end
    end

    // Next-address and stack request decode. Overflow/underflow fall through to next.
    always_comb begin
        w_addr_nxt = r_addr;
        w_push     = 1'b0;
        w_pop      = 1'b0;
`ifdef MICROSEQ_LOOP_EN
        w_cnt_nxt  = r_cnt;
`endif
        case (w_cmd)
            NOP:    w_addr_nxt = r_addr;
            INC:    w_addr_nxt = w_next;
            JMP:    w_addr_nxt = load_addr;
            JCC:    w_addr_nxt = w_cond ? load_addr : w_next;
            CALL, CALLCC: begin
                if (w_cmd == CALL || w_cond) begin
                    w_push     = 1'b1;
                    w_addr_nxt = w_full ? w_next : load_addr;
                end else begin
                    w_addr_nxt = w_next;
                end
            end
            RET, RETCC: begin
                if (w_cmd == RET || w_cond) begin
                    w_pop      = 1'b1;
                    w_addr_nxt = w_empty ? w_next : w_top;
                end else begin
                    w_addr_nxt = w_next;
                end
            end
`ifdef MICROSEQ_LOOP_EN
            LDCNT: begin
                w_cnt_nxt  = load_addr[CNT_W-1:0];
                w_addr_nxt = w_next;
            end
            DJNZ: begin
                w_addr_nxt = w_next;
                if (r_cnt != '0) begin
                    w_cnt_nxt = w_cnt_dec;
                    if (w_cnt_dec != '0) w_addr_nxt = load_addr;
                end
            end
`else
            LDCNT:  w_addr_nxt = w_next;
            DJNZ:   w_addr_nxt = w_next;
`endif
            default: w_addr_nxt = RESET_ADDR;
        endcase
    end

    microseq_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push & ~stall & ~reset),
        .i_pop   (w_pop & ~stall & ~reset),
        .i_data  (w_next),
        .o_top   (w_top),
        .o_count (sp),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_ovf   (w_ovf),
        .o_unf   (w_unf)
    );

    // Address, sticky error and loop count; stall freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= RESET_ADDR;
            r_err  <= 1'b0;
`ifdef MICROSEQ_LOOP_EN
            r_cnt  <= '0;
`endif
        end else if (!stall) begin
            r_addr <= w_addr_nxt;
            r_err  <= r_err | w_ovf | w_unf;
`ifdef MICROSEQ_LOOP_EN
            r_cnt  <= w_cnt_nxt;
`endif
        end
    end

    assign addr      = r_addr;
    assign stack_err = r_err;

endmodule

// File: tb/tb_microseq.sv
// Directed-vector bench for microseq (NFLAGS=3, RESET_ADDR=0x10).
// Loop expectations follow MICROSEQ_LOOP_EN.
module tb_microseq;
    import microseq_types::*;

    localparam int ADDR_W = 8;

    typedef struct {
        logic       rst;
        logic       stl;
        logic [3:0] cmd;
        logic [1:0] sel;
        logic       inv;
        logic [2:0] flg;
        logic [7:0] ld;
        logic [7:0] e_addr;
        logic [2:0] e_sp;
        logic       e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic [1:0] cond_sel = 2'd0;
    logic       cond_inv = 1'b0;
    logic [2:0] flags = 3'd0;
    logic [7:0] load_addr = 8'd0;
    logic [7:0] addr;
    logic [2:0] sp;
    logic       stack_err;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vq[$];

    microseq #(
        .ADDR_W(ADDR_W), .STACK_DEPTH(4), .NFLAGS(3), .CNT_W(8), .RESET_ADDR(8'h10)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .cmd(cmd), .cond_sel(cond_sel),
        .cond_inv(cond_inv), .flags(flags), .load_addr(load_addr),
        .addr(addr), .sp(sp), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic stl, input logic [3:0] c,
                       input logic [1:0] s, input logic i, input logic [2:0] f,
                       input logic [7:0] ld, input logic [7:0] ea,
                       input logic [2:0] es, input logic ee);
        vec_t v;
        v.rst = rst; v.stl = stl; v.cmd = c; v.sel = s; v.inv = i; v.flg = f;
        v.ld = ld; v.e_addr = ea; v.e_sp = es; v.e_err = ee;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rst; stall = v.stl; cmd = v.cmd; cond_sel = v.sel;
        cond_inv = v.inv; flags = v.flg; load_addr = v.ld;
        @(posedge clk);
        #1;
        chk("addr", idx, 32'(addr), 32'(v.e_addr));
        chk("sp", idx, 32'(sp), 32'(v.e_sp));
        chk("stack_err", idx, 32'(stack_err), 32'(v.e_err));
    endtask

    initial begin
        // rst stl cmd sel inv flg ld -> addr sp err
        add(1, 0, NOP,    0, 0, 3'b000, 8'h00, 8'h10, 0, 0);
        add(0, 0, INC,    0, 0, 3'b000, 8'h00, 8'h11, 0, 0);
        add(0, 0, INC,    0, 0, 3'b000, 8'h00, 8'h12, 0, 0);
        add(0, 0, INC,    0, 0, 3'b000, 8'h00, 8'h13, 0, 0);
        add(0, 0, JMP,    0, 0, 3'b000, 8'h20, 8'h20, 0, 0);
        add(0, 0, CALL,   0, 0, 3'b000, 8'h40, 8'h40, 1, 0);
        add(0, 0, INC,    0, 0, 3'b000, 8'h00, 8'h41, 1, 0);
        add(0, 0, RET,    0, 0, 3'b000, 8'h00, 8'h21, 0, 0);
        add(0, 0, JMP,    0, 0, 3'b000, 8'h30, 8'h30, 0, 0);
        add(0, 0, JCC,    0, 0, 3'b001, 8'h80, 8'h80, 0, 0);
        add(0, 0, JMP,    0, 0, 3'b000, 8'h30, 8'h30, 0, 0);
        add(0, 0, JCC,    0, 1, 3'b001, 8'h80, 8'h31, 0, 0);
        add(0, 0, JCC,    3, 0, 3'b111, 8'h80, 8'h32, 0, 0);
        add(0, 0, JCC,    3, 1, 3'b000, 8'h80, 8'h80, 0, 0);
        add(0, 0, JCC,    2, 0, 3'b100, 8'h44, 8'h44, 0, 0);
        add(0, 0, CALLCC, 1, 0, 3'b000, 8'h90, 8'h45, 0, 0);
        add(0, 0, CALLCC, 1, 0, 3'b010, 8'h90, 8'h90, 1, 0);
        add(0, 0, RETCC,  0, 0, 3'b000, 8'h00, 8'h91, 1, 0);
        add(0, 0, RETCC,  0, 0, 3'b001, 8'h00, 8'h46, 0, 0);
        add(0, 0, 4'd12,  0, 0, 3'b000, 8'h77, 8'h10, 0, 0);
        add(0, 0, NOP,    0, 0, 3'b000, 8'h77, 8'h10, 0, 0);
        // stall and reset interplay
        add(0, 0, JMP,    0, 0, 3'b000, 8'h05, 8'h05, 0, 0);
        add(0, 1, CALL,   0, 0, 3'b000, 8'h60, 8'h05, 0, 0);
        add(0, 0, CALL,   0, 0, 3'b000, 8'h60, 8'h60, 1, 0);
        add(0, 1, RET,    0, 0, 3'b000, 8'h00, 8'h60, 1, 0);
        add(0, 0, RET,    0, 0, 3'b000, 8'h00, 8'h06, 0, 0);
        add(0, 1, RET,    0, 0, 3'b000, 8'h00, 8'h06, 0, 0);
        add(0, 0, CALL,   0, 0, 3'b000, 8'h70, 8'h70, 1, 0);
        add(0, 0, RET,    0, 0, 3'b000, 8'h00, 8'h07, 0, 0);
        add(0, 0, RET,    0, 0, 3'b000, 8'h00, 8'h08, 0, 1);
        add(0, 0, CALL,   0, 0, 3'b000, 8'h80, 8'h80, 1, 1);
        add(1, 1, CALL,   0, 0, 3'b000, 8'h90, 8'h10, 0, 0);
        add(0, 0, RET,    0, 0, 3'b000, 8'h00, 8'h11, 0, 1);
        add(1, 0, NOP,    0, 0, 3'b000, 8'h00, 8'h10, 0, 0);
        // address wrap
        add(0, 0, JMP,    0, 0, 3'b000, 8'hFF, 8'hFF, 0, 0);
        add(0, 0, INC,    0, 0, 3'b000, 8'h00, 8'h00, 0, 0);
        // loop counter
        add(0, 0, JMP,    0, 0, 3'b000, 8'h50, 8'h50, 0, 0);
        add(0, 0, LDCNT,  0, 0, 3'b000, 8'h03, 8'h51, 0, 0);
`ifdef MICROSEQ_LOOP_EN
        add(0, 0, DJNZ,   0, 0, 3'b000, 8'h50, 8'h50, 0, 0);
        add(0, 0, DJNZ,   0, 0, 3'b000, 8'h50, 8'h50, 0, 0);
        add(0, 0, DJNZ,   0, 0, 3'b000, 8'h50, 8'h51, 0, 0);
        add(0, 0, DJNZ,   0, 0, 3'b000, 8'h50, 8'h52, 0, 0);
        add(0, 0, LDCNT,  0, 0, 3'b000, 8'h02, 8'h53, 0, 0);
        add(0, 1, DJNZ,   0, 0, 3'b000, 8'h50, 8'h53, 0, 0);
        add(0, 0, DJNZ,   0, 0, 3'b000, 8'h50, 8'h50, 0, 0);
        add(0, 0, DJNZ,   0, 0, 3'b000, 8'h50, 8'h51, 0, 0);
`else
        add(0, 0, DJNZ,   0, 0, 3'b000, 8'h50, 8'h52, 0, 0);
        add(0, 0, DJNZ,   0, 0, 3'b000, 8'h50, 8'h53, 0, 0);
        add(0, 0, DJNZ,   0, 0, 3'b000, 8'h50, 8'h54, 0, 0);
        add(0, 0, DJNZ,   0, 0, 3'b000, 8'h50, 8'h55, 0, 0);
`endif

        reset = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Nested calls past the stack depth, then unwind past empty.
        begin
            vec_t v;
            int base;
            base = 1000;
            v = '{rst:0, stl:0, cmd:JMP, sel:0, inv:0, flg:0, ld:8'hA0,
                  e_addr:8'hA0, e_sp:0, e_err:0};
            apply(v, base);
            for (int k = 1; k <= 5; k++) begin
                v.cmd = CALL;
                v.ld  = 8'(8'hA0 + k * 8'h10);
                v.e_addr = (k <= 4) ? v.ld : 8'hE1;
                v.e_sp   = 3'((k <= 4) ? k : 4);
                v.e_err  = (k == 5);
                apply(v, base + k);
            end
            for (int k = 1; k <= 5; k++) begin
                v.cmd = RET;
                v.ld  = 8'h00;
                v.e_addr = (k <= 4) ? 8'(8'hE1 - k * 8'h10) : 8'hA2;
                v.e_sp   = 3'((k <= 4) ? 4 - k : 0);
                v.e_err  = 1'b1;
                apply(v, base + 5 + k);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/microseq.md
# microseq

Parametrised microsequencer: holds the microprogram address, computes the next address from a command, flag conditions, a hardware call stack and an optional loop counter. It drives the microcode ROM address and generalises the fixed 4-deep, single-flag microaddress counter. Address width, stack depth and flag count are parameters. Stack overflow and underflow are detected, and a stall input freezes all state.

## Interface
- ADDR_W, default 8: microaddress width.
- STACK_DEPTH, default 4: return-stack entries; must be a power of 2, at least 2.
- NFLAGS, default 4: number of condition flags; at least 1.
- CNT_W, default 8: loop counter width; must be no greater than ADDR_W.
- RESET_ADDR, default 0: address loaded on reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  when 1, all state holds.
- cmd  in  4  microseq_types::cmd_t command.
- cond_sel  in  max(1,$clog2(NFLAGS))  selects the flag for conditional commands.
- cond_inv  in  1  inverts the selected flag.
- flags  in  NFLAGS  condition flags, e.g. bit 0 = Z.
- load_addr  in  ADDR_W  target address; for LDCNT, the count value.
- addr  out  ADDR_W  current microaddress (registered).
- sp  out  $clog2(STACK_DEPTH)+1  number of stack entries in use, 0..STACK_DEPTH.
- stack_err  out  1  sticky flag for stack overflow or underflow.

## Operation
- Condition: cond = flags[cond_sel] ^ cond_inv. If cond_sel ≥ NFLAGS, the flag value is 0.
- "Next" below means (addr+1) mod 2^ADDR_W. Address wrap is silent.
- NOP=0: addr holds.
- INC=1: addr ← next.
- JMP=2: addr ← load_addr.
- JCC=3: if cond, addr ← load_addr; otherwise addr ← next.
- CALL=4: push next, sp ← sp+1, addr ← load_addr.
- CALLCC=5: if cond, behaves as CALL; otherwise addr ← next.
- RET=6: addr ← stack[sp-1], sp ← sp-1.
- RETCC=7: if cond, behaves as RET; otherwise addr ← next.
- LDCNT=8: count ← load_addr[CNT_W-1:0], addr ← next.
- DJNZ=9: applies only when count ≠ 0:
  - count ← count-1.
  - If count-1 ≠ 0, addr ← load_addr; otherwise addr ← next.
  - If count = 0: count stays 0, addr ← next.
- Codes 10–15 are illegal: addr ← RESET_ADDR; sp, count and the stack are unchanged.
- Overflow: a taken CALL or CALLCC when sp = STACK_DEPTH. The push is suppressed, sp is unchanged, addr ← next, stack_err ← 1.
- Underflow: a taken RET or RETCC when sp = 0. sp stays 0, addr ← next, stack_err ← 1.
- stack_err stays set until reset.

## Timing
- All outputs are registered. A command presented in cycle N takes effect on addr, sp and count at edge N+1.
- Latency is 1 cycle. Back-to-back commands are allowed every cycle.
- cmd, cond_sel, cond_inv, flags and load_addr are sampled only at the rising edge.
- stall=1: addr, sp, count, stack contents and stack_err all hold, regardless of cmd.
- Reset has priority over stall and cmd. Reset values:
  - addr = RESET_ADDR, sp = 0, count = 0, stack_err = 0.
  - Stack contents are not reset.
- Reset mid-call-chain discards all return addresses; sp reads 0 the next cycle.
- An error condition and stall in the same cycle: stall wins, and no error is flagged.

## Configuration
- MICROSEQ_LOOP_EN defined: the count register, LDCNT and DJNZ are implemented.
- MICROSEQ_LOOP_EN undefined:
  - No count register is built and CNT_W is ignored.
  - LDCNT and DJNZ decode as INC: addr ← next, no other effect.

## Structure
- Package microseq_types holds:
  - cmd_t, a 4-bit enum with the encodings above.
  - Command-width constant CMD_W = 4.
- Address-dependent types stay in the module because ADDR_W is a parameter.
- Sub-module microseq_stack is a parametrised LIFO (ADDR_W, STACK_DEPTH).
  - Inputs: push, pop, push data.
  - Outputs: top, count, full, empty.
  - Overflow and underflow suppression lives inside it; the error outputs feed stack_err.

## Test plan
- Reset with RESET_ADDR=0x10, cmd=INC for 3 cycles -> addr = 0x10, 0x11, 0x12, 0x13; sp=0; stack_err=0.
- At addr=0x20: CALL 0x40, then INC, then RET -> addr = 0x40, 0x41, 0x21; sp goes 1 then 0.
- flags=4'b0001, JCC with sel=0, inv=0, target 0x80 from 0x30 -> addr=0x80. Same with inv=1 -> addr=0x31. sel=3 with NFLAGS=3 -> falls through.
- Five nested CALLs with STACK_DEPTH=4 -> sp=4 after 4 calls; 5th call gives addr=next, stack_err=1. Then 5 RETs -> 4 correct returns, 5th gives addr=next, sp=0.
- MICROSEQ_LOOP_EN: LDCNT 3, then DJNZ to 0x50 repeatedly from 0x51 -> jumps twice, falls through on the 3rd with count=0. Without the macro -> each acts as INC.
- stall=1 during CALL 0x60 from 0x05 -> addr=0x05, sp unchanged. Reset asserted with stall=1 -> addr=RESET_ADDR, sp=0, stack_err=0. addr=0xFF, INC -> addr=0x00.
